ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Execute-stage RV32M multiply/divide unit, downstream of the ID/EX pipeline register. It consumes ALU_OP and the two register operands and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively. While an operation is in progress it raises STALL, and the pipeline freezes the ID/EX and earlier registers. The result is muxed into the EX result path alongside the main ALU.

Parameters:
DATA_W, 32, operand/result width; only 32 is supported and verified
CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-high reset; sampled on posedge CLK
ALU_OP  input  5  operation code from the ID/EX register
DATA1  input  32  rs1 operand (ID/EX OUT1)
DATA2  input  32  rs2 operand (ID/EX OUT2)
HOLD  input  1  downstream memory BUSY_WAIT; pipeline is frozen this cycle
RESULT  output  32  registered result; valid when RESULT_VALID=1
RESULT_VALID  output  1  high in DONE state
STALL  output  1  combinational; freezes upstream pipeline registers

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RESET); it is sampled only on posedge CLK.
- ALU_OP decode:
  - 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU
  - 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU
  - Any other code is not an M-op; the unit stays idle.
- Reset (RESET=1 at posedge):
  - state=IDLE, RESULT=0, RESULT_VALID=0, counter=0, internal regs=0.
  - STALL=0 whenever RESET=1, even combinationally.
  - Reset mid-operation aborts the operation; the next cycle is IDLE, with no result produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - STALL = is_m_op(ALU_OP).
  - On posedge with an M-op, latch the op and the operand magnitudes plus sign flags (sign per op: MULHSU has rs1 signed, rs2 unsigned; the U ops are unsigned), and set counter=0.
  - Next state: MUL for 0100x/0101x; DIV otherwise.
  - Divide fast paths go directly to DONE:
    - DATA2=0: quotient=0xFFFFFFFF, remainder=DATA1.
    - Signed overflow (DIV/REM with DATA1=0x80000000, DATA2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- MUL:
  - Radix-2 shift-add over a 64-bit product of magnitudes, one bit per cycle.
  - Runs 32 cycles (counter 0..31). STALL=1.
  - On counter==31 go to DONE. The sign-corrected 64-bit product is written to RESULT: low word for MUL, high word for the others.
- DIV:
  - Restoring division, one quotient bit per cycle, 32 cycles. STALL=1.
  - Sign correction on exit: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - RESULT = quotient for DIV/DIVU, remainder for REM/REMU.
- DONE:
  - RESULT_VALID=1, STALL=0.
  - If HOLD=1, stay in DONE with RESULT stable and no restart.
  - Otherwise go to IDLE on the next posedge; the pipeline advances on the same edge.
- Latency:
  - Normal op: 33 STALL cycles (1 IDLE + 32 iteration), then 1 DONE cycle.
  - Divide fast path: 1 STALL cycle, then DONE.
- Back-to-back M-ops: each new op is detected in IDLE after DONE, so there is one non-stall cycle between ops.
- RESULT holds its last value outside DONE and is not cleared except by reset.
- Arithmetic: all internal add/sub is done at 33/64 bits. Negation is two's complement, and wrap-around is intended.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiplies are computed by a single combinational 33x33 signed multiply. IDLE goes straight to DONE, giving 1 STALL cycle per multiply. The MUL state is not generated. Divide behaviour is unchanged.
- Undefined: multiplies use the 32-cycle iterative path described above.

Test Plan:
- MUL DATA1=7, DATA2=0xFFFFFFFD → STALL high 33 cycles, then RESULT=0xFFFFFFEB with RESULT_VALID=1 for 1 cycle (1 STALL cycle with MULDIV_FAST_MUL_EN).
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; each after 33 STALL cycles.
- DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM same → 0; each with exactly 1 STALL cycle.
- HOLD=1 for 3 cycles on DONE entry → RESULT_VALID and RESULT stable for 4 cycles, STALL=0, no second operation started.
- RESET asserted on the 10th DIV iteration cycle → next cycle state IDLE, STALL=0, RESULT=0, RESULT_VALID=0; a new op then completes correctly.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Optional single-cycle multiplier selected by defining MULDIV_FAST_MUL_EN.
module ex_muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [4:0]        ALU_OP,
   input  logic [DATA_W-1:0] DATA1,
   input  logic [DATA_W-1:0] DATA2,
   input  logic              HOLD,
   output logic [DATA_W-1:0] RESULT,
   output logic              RESULT_VALID,
   output logic              STALL
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifndef MULDIV_FAST_MUL_EN
      S_MUL  = 2'd1,
`endif
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [DATA_W-1:0]     a_q, a_d;
   logic [2*DATA_W-1:0]   acc_q, acc_d;
   logic                  qneg_q, qneg_d;
   logic                  rneg_q, rneg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     result_q, result_d;
   logic                  valid_q, valid_d;
   logic                  stall_s;

   logic                  is_m_op_s;
   logic [2:0]            op_s;
   logic                  s1_signed_s, s2_signed_s;
   logic                  neg1_s, neg2_s;
   logic [DATA_W-1:0]     mag1_s, mag2_s;
   logic                  div0_s, ovf_s;
   logic                  last_s;

   logic [DATA_W:0]       div_shift_s, div_diff_s;
   logic [2*DATA_W-1:0]   div_next_s;
   logic [DATA_W-1:0]     quot_fix_s, rem_fix_s;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*DATA_W-1:0]   fast_a_s, fast_b_s, fast_prod_s;
`else
   logic [DATA_W:0]       mul_sum_s;
   logic [2*DATA_W-1:0]   mul_next_s, prod_fix_s;
`endif

   // Operand decode: signedness per op, magnitudes and divide fast-path detection.
   always_comb begin
      is_m_op_s = (ALU_OP[4:3] == 2'b01);
      op_s      = ALU_OP[2:0];
      case (op_s)
         3'b000, 3'b001, 3'b100, 3'b110: begin s1_signed_s = 1'b1; s2_signed_s = 1'b1; end
         3'b010:                         begin s1_signed_s = 1'b1; s2_signed_s = 1'b0; end
         default:                        begin s1_signed_s = 1'b0; s2_signed_s = 1'b0; end
      endcase
      neg1_s = s1_signed_s & DATA1[DATA_W-1];
      neg2_s = s2_signed_s & DATA2[DATA_W-1];
      mag1_s = neg1_s ? -DATA1 : DATA1;
      mag2_s = neg2_s ? -DATA2 : DATA2;
      div0_s = (DATA2 == {DATA_W{1'b0}});
      ovf_s  = s1_signed_s && op_s[2] && (DATA1 == {1'b1, {(DATA_W-1){1'b0}}}) &&
               (DATA2 == {DATA_W{1'b1}});
      last_s = (cnt_q == CNT_W'(DATA_W-1));
   end

   // One iteration of each datapath; acc holds {partial, multiplier} or {remainder, quotient}.
   always_comb begin
`ifdef MULDIV_FAST_MUL_EN
      fast_a_s    = {{DATA_W{s1_signed_s & DATA1[DATA_W-1]}}, DATA1};
      fast_b_s    = {{DATA_W{s2_signed_s & DATA2[DATA_W-1]}}, DATA2};
      fast_prod_s = fast_a_s * fast_b_s;
`else
      mul_sum_s   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                    (acc_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
      mul_next_s  = {mul_sum_s, acc_q[DATA_W-1:1]};
      prod_fix_s  = qneg_q ? -mul_next_s : mul_next_s;
`endif
      div_shift_s = acc_q[2*DATA_W-1:DATA_W-1];
      div_diff_s  = div_shift_s - {1'b0, a_q};
      if (div_diff_s[DATA_W]) begin
         div_next_s = {div_shift_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
      end else begin
         div_next_s = {div_diff_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      end
      quot_fix_s = qneg_q ? -div_next_s[DATA_W-1:0] : div_next_s[DATA_W-1:0];
      rem_fix_s  = rneg_q ? -div_next_s[2*DATA_W-1:DATA_W] : div_next_s[2*DATA_W-1:DATA_W];
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      acc_d    = acc_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      stall_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_s = is_m_op_s;
            if (is_m_op_s) begin
               op_d   = op_s;
               cnt_d  = {CNT_W{1'b0}};
               qneg_d = neg1_s ^ neg2_s;
               rneg_d = neg1_s;
               if (op_s[2]) begin
                  a_d   = mag2_s;
                  acc_d = {{DATA_W{1'b0}}, mag1_s};
                  if (div0_s) begin
                     result_d = op_s[1] ? DATA1 : {DATA_W{1'b1}};
                     state_d  = S_DONE;
                  end else if (ovf_s) begin
                     result_d = op_s[1] ? {DATA_W{1'b0}} : {1'b1, {(DATA_W-1){1'b0}}};
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_DIV;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  result_d = (op_s == 3'b000) ? fast_prod_s[DATA_W-1:0]
                                              : fast_prod_s[2*DATA_W-1:DATA_W];
                  state_d  = S_DONE;
`else
                  a_d      = mag1_s;
                  acc_d    = {{DATA_W{1'b0}}, mag2_s};
                  state_d  = S_MUL;
`endif
               end
            end else begin
               state_d = S_IDLE;
            end
         end
`ifndef MULDIV_FAST_MUL_EN
         S_MUL: begin
            stall_s = 1'b1;
            acc_d   = mul_next_s;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_s) begin
               result_d = (op_q == 3'b000) ? prod_fix_s[DATA_W-1:0]
                                           : prod_fix_s[2*DATA_W-1:DATA_W];
               state_d  = S_DONE;
            end else begin
               state_d  = S_MUL;
            end
         end
`endif
         S_DIV: begin
            stall_s = 1'b1;
            acc_d   = div_next_s;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_s) begin
               result_d = op_q[1] ? rem_fix_s : quot_fix_s;
               state_d  = S_DONE;
            end else begin
               state_d  = S_DIV;
            end
         end
         S_DONE: begin
            // HOLD keeps the result presented until the frozen pipeline can take it.
            if (HOLD) begin
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      valid_d = (state_d == S_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         op_q     <= 3'd0;
         a_q      <= {DATA_W{1'b0}};
         acc_q    <= {(2*DATA_W){1'b0}};
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         result_q <= {DATA_W{1'b0}};
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign STALL        = RESET ? 1'b0 : stall_s;
   assign RESULT       = result_q;
   assign RESULT_VALID = valid_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed table, hold/reset sequences, random ops vs model.
module tb_ex_muldiv_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [4:0]  ALU_OP;
   logic [31:0] DATA1, DATA2;
   logic        HOLD;
   logic [31:0] RESULT;
   logic        RESULT_VALID;
   logic        STALL;

   always #5 CLK = ~CLK;

   ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .CLK(CLK), .RESET(RESET), .ALU_OP(ALU_OP), .DATA1(DATA1), .DATA2(DATA2),
      .HOLD(HOLD), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .STALL(STALL)
   );

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   localparam logic [4:0] OP_MUL = 5'b01000, OP_MULH = 5'b01001, OP_MULHSU = 5'b01010,
                          OP_MULHU = 5'b01011, OP_DIV = 5'b01100, OP_DIVU = 5'b01101,
                          OP_REM = 5'b01110, OP_REMU = 5'b01111;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic and SV division, RISC-V special cases.
   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] ea, eb, p;
      logic        sa, sb;
      if (op[2] == 1'b0) begin
         sa = (op[1:0] != 2'b11);
         sb = (op[1] == 1'b0);
         ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
         eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
         p  = ea * eb;
         return (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0] == 1'b0) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
         return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      end
      return op[1] ? a % b : a / b;
   endfunction

   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] == 1'b0) return MUL_LAT;
      if (b == 32'd0) return 1;
      if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output int stalls,
                         output int vcyc, output logic stable_ok);
      int n;
      @(negedge CLK);
      ALU_OP = op; DATA1 = a; DATA2 = b; HOLD = 1'b0;
      #1;
      stalls = 0;
      n = 0;
      while (!RESULT_VALID && n < 200) begin
         if (STALL) stalls++;
         n++;
         @(negedge CLK); #1;
      end
      res = RESULT;
      vcyc = 0;
      stable_ok = 1'b1;
      while (RESULT_VALID && vcyc < 20) begin
         vcyc++;
         if (RESULT !== res || STALL !== 1'b0) stable_ok = 1'b0;
         if (vcyc <= hold) begin
            HOLD = 1'b1;
         end else begin
            HOLD = 1'b0;
            ALU_OP = 5'b00000;
         end
         @(negedge CLK); #1;
      end
      HOLD = 1'b0;
      ALU_OP = 5'b00000;
   endtask

   task automatic do_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input int hold);
      logic [31:0] res;
      int stalls, vcyc;
      logic stable_ok;
      run_op(op, a, b, hold, res, stalls, vcyc, stable_ok);
      check({name, " result"}, res, exp);
      check({name, " stall cycles"}, 32'(stalls), 32'(lat));
      check({name, " valid cycles"}, 32'(vcyc), 32'(hold + 1));
      check({name, " done stable"}, {31'd0, stable_ok}, 32'd1);
      check({name, " idle stall"}, {31'd0, STALL}, 32'd0);
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{"mul_7_m3",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
      tbl[1]  = '{"mulhu_m1_m1",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
      tbl[2]  = '{"mulh_m1_m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
      tbl[3]  = '{"mulhsu_m1_2",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT};
      tbl[4]  = '{"div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      tbl[5]  = '{"rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      tbl[6]  = '{"divu_100_7",    OP_DIVU,   32'd100,       32'd7,         32'd14,        33};
      tbl[7]  = '{"remu_100_7",    OP_REMU,   32'd100,       32'd7,         32'd2,         33};
      tbl[8]  = '{"divu_5_0",      OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      tbl[9]  = '{"rem_5_0",       OP_REM,    32'd5,         32'd0,         32'd5,         1};
      tbl[10] = '{"div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      tbl[11] = '{"rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};

      RESET = 1'b1; ALU_OP = OP_DIVU; DATA1 = 32'd9; DATA2 = 32'd3; HOLD = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      check("stall masked by reset", {31'd0, STALL}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0; ALU_OP = 5'b00000;
      #1;
      check("reset result", RESULT, 32'd0);
      check("reset valid", {31'd0, RESULT_VALID}, 32'd0);
      check("reset stall", {31'd0, STALL}, 32'd0);

      ALU_OP = 5'b10000;
      repeat (3) @(negedge CLK);
      ALU_OP = 5'b00111;
      #1;
      check("non-m-op stall", {31'd0, STALL}, 32'd0);
      @(negedge CLK); #1;
      check("non-m-op valid", {31'd0, RESULT_VALID}, 32'd0);
      ALU_OP = 5'b00000;

      for (int i = 0; i < 12; i++) begin
         do_vec(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0);
      end

      // HOLD for three cycles on DONE entry, M-op left on the bus to catch restarts.
      do_vec("hold_divu", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33, 3);
      do_vec("hold_mul", OP_MUL, 32'd12, 32'd11, 32'd132, MUL_LAT, 3);

      // Reset in the 10th divide iteration aborts with no result.
      do_vec("pre_reset_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
      @(negedge CLK);
      ALU_OP = OP_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
      repeat (10) @(negedge CLK);
      #1;
      check("mid div stall", {31'd0, STALL}, 32'd1);
      RESET = 1'b1;
      #1;
      check("stall under reset", {31'd0, STALL}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0; ALU_OP = 5'b00000;
      #1;
      check("abort stall", {31'd0, STALL}, 32'd0);
      check("abort result", RESULT, 32'd0);
      check("abort valid", {31'd0, RESULT_VALID}, 32'd0);
      @(negedge CLK); #1;
      check("abort no late valid", {31'd0, RESULT_VALID}, 32'd0);
      do_vec("post_reset_rem", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 0);

      for (int i = 0; i < 60; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         int          sel;
         op  = {2'b01, 3'($urandom_range(0, 7))};
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         do_vec($sformatf("rand%0d_op%b", i, op), op, a, b, ref_result(op, a, b),
                ref_lat(op, a, b), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
